// File: rtl/shift_pkg.sv
// Shared constants, FSM state type and helpers for the sequential symbol left-shifter.
// A word is NUM_SYM symbols of SYM_W bits; symbol i occupies bits [SYM_W*i +: SYM_W].
package shift_pkg;

  localparam int unsigned SYM_W     = 5;
  localparam int unsigned NUM_SYM   = 10;
  localparam int unsigned DATA_W    = SYM_W * NUM_SYM;
  localparam int unsigned SHIFT_W   = 3;
  localparam int unsigned MAX_SHIFT = 4;

  // Sized copy of MAX_SHIFT so comparisons against the shift input stay width-matched.
  localparam logic [SHIFT_W-1:0] MaxShiftVal = SHIFT_W'(MAX_SHIFT);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Builds a word with every symbol equal to sym.
  function automatic logic [DATA_W-1:0] replicate_sym(input logic [SYM_W-1:0] sym);
    return {NUM_SYM{sym}};
  endfunction

endpackage

// File: rtl/shift_left_sym_step.sv
// One-symbol left shift with fill.
// Ports:
//   data_i  word to shift
//   fill_i  symbol inserted at symbol 0
//   data_o  data_i shifted left by one symbol; the top symbol is discarded
module shift_left_sym_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [SYM_W-1:0]  fill_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = {data_i[DATA_W-SYM_W-1:0], fill_i};

endmodule

// File: rtl/shift_left_seq.sv
// Sequential symbol left-shifter with valid/ready handshakes on both sides.
// Shifts a word left by 0..MAX_SHIFT symbols, one symbol per clock, filling vacated low
// symbols with a fill symbol captured at accept. Larger shift amounts produce a word made
// entirely of the fill symbol and raise out_err.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in, shift, fill sampled only on accept
//   out_valid / out_ready output handshake; out and out_err hold while stalled
//   out                  result word (shows the working register in every state)
//   out_err              shift amount of the current result was out of range
module shift_left_seq
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [SYM_W-1:0]   fill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out,
  output logic               out_err
);

  state_e             state;
  logic [DATA_W-1:0]  data;
  logic [DATA_W-1:0]  data_step;
  logic [SYM_W-1:0]   fill_q;
  logic [SHIFT_W-1:0] cnt;
  logic               err_q;
  logic               accept;

  shift_left_sym_step u_step (
    .data_i (data),
    .fill_i (fill_q),
    .data_o (data_step)
  );

  // A result being consumed frees the block in the same cycle, so a new word can load
  // on the handshake edge without a bubble.
  assign in_ready  = (state == StIdle) | ((state == StDone) & out_ready);
  assign accept    = in_valid & in_ready;

  assign out_valid = (state == StDone);
  assign out       = data;
  assign out_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      data   <= '0;
      fill_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data   <= in;
      fill_q <= fill;
      err_q  <= 1'b0;
      if (shift == '0) begin
        state <= StDone;
      end else if (shift <= MaxShiftVal) begin
        cnt   <= shift;
        state <= StShift;
      end else begin
        data  <= replicate_sym(fill);
        err_q <= 1'b1;
        state <= StDone;
      end
    end else begin
      case (state)
        StShift: begin
          data <= data_step;
          cnt  <= cnt - SHIFT_W'(1);
          // cnt is at least 1 on entry, so the last step is the one that sees 1.
          if (cnt == SHIFT_W'(1)) begin
            state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_left_seq.sv
module tb_shift_left_seq;
  import shift_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  din;
  logic [SHIFT_W-1:0] shift;
  logic [SYM_W-1:0]   fill;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  dout;
  logic               out_err;

  shift_left_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .shift     (shift),
    .fill      (fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] exp_out;
    logic              exp_err;
    int                lat;
    int                acc;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0]  d;
    logic [SHIFT_W-1:0] sh;
    logic [SYM_W-1:0]   f;
    logic [DATA_W-1:0]  exp_out;
    logic               exp_err;
    int                 lat;
  } vec_t;

  exp_t q[$];
  exp_t cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int s9, input int s8, input int s7,
                                           input int s6, input int s5, input int s4,
                                           input int s3, input int s2, input int s1,
                                           input int s0);
    return {5'(s9), 5'(s8), 5'(s7), 5'(s6), 5'(s5), 5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  // Reference: shifting left k symbols drops the top k and appends k fill symbols.
  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d,
                                              input logic [SHIFT_W-1:0] sh,
                                              input logic [SYM_W-1:0] f);
    logic [DATA_W-1:0] r;
    if (int'(sh) > 4) return {10{f}};
    r = d;
    for (int i = 0; i < int'(sh); i++) r = {r[DATA_W-6:0], f};
    return r;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge; stimulus changes at posedge+2.
  logic              prev_ov, prev_hs, held, held_err, hs;
  logic [DATA_W-1:0] held_out;
  exp_t              e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_hs = 1'b0;
      held    = 1'b0;
    end else begin
      if (out_valid && (!prev_ov || prev_hs)) begin
        if (q.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
        else chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
      end
      if (held && out_valid) begin
        chk("stall_out_stable", 64'(dout), 64'(held_out));
        chk("stall_err_stable", 64'(out_err), 64'(held_err));
      end
      hs = out_valid && out_ready;
      if (hs) begin
        if (q.size() == 0) begin
          chk("handshake_without_expect", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("out", 64'(dout), 64'(e.exp_out));
          chk("out_err", 64'(out_err), 64'(e.exp_err));
        end
      end
      if (out_valid && !out_ready) begin
        held     = 1'b1;
        held_out = dout;
        held_err = out_err;
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) begin
        e     = cur;
        e.acc = cyc + 1;
        q.push_back(e);
      end
      prev_ov = out_valid;
      prev_hs = hs;
    end
  end

  task automatic scramble();
    din   = {18'($urandom), $urandom};
    shift = 3'($urandom);
    fill  = 5'($urandom);
  endtask

  // Presents one word and returns at posedge+2 after it has been accepted.
  task automatic send(input vec_t v);
    bit ok;
    ok = 0;
    cur.exp_out = v.exp_out;
    cur.exp_err = v.exp_err;
    cur.lat     = v.lat;
    cur.acc     = 0;
    in_valid = 1'b1;
    din      = v.d;
    shift    = v.sh;
    fill     = v.f;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  vec_t              tbl[$];
  vec_t              v;
  logic [DATA_W-1:0] base;
  bit                seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    shift     = '0;
    fill      = '0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out", 64'(dout), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));

    base = mk(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
    tbl.push_back('{base, 3'd2, 5'd31, mk(7, 6, 5, 4, 3, 2, 1, 0, 31, 31), 1'b0, 3});
    tbl.push_back('{base, 3'd0, 5'd17, base, 1'b0, 1});
    tbl.push_back('{base, 3'd4, 5'd0, mk(5, 4, 3, 2, 1, 0, 0, 0, 0, 0), 1'b0, 5});
    tbl.push_back('{base, 3'd5, 5'd21, mk(21, 21, 21, 21, 21, 21, 21, 21, 21, 21), 1'b1, 1});
    tbl.push_back('{base, 3'd7, 5'd3, mk(3, 3, 3, 3, 3, 3, 3, 3, 3, 3), 1'b1, 1});
    tbl.push_back('{base, 3'd1, 5'd10, mk(8, 7, 6, 5, 4, 3, 2, 1, 0, 10), 1'b0, 2});
    tbl.push_back('{base, 3'd3, 5'd30, mk(6, 5, 4, 3, 2, 1, 0, 30, 30, 30), 1'b0, 4});
    for (int i = 0; i < 6; i++) begin
      v.d       = {18'($urandom), $urandom};
      v.sh      = 3'($urandom_range(0, 7));
      v.f       = 5'($urandom);
      v.exp_out = model(v.d, v.sh, v.f);
      v.exp_err = (int'(v.sh) > 4);
      v.lat     = (int'(v.sh) > 4) ? 1 : int'(v.sh) + 1;
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      send(tbl[i]);
      if (tbl[i].sh != 0 && int'(tbl[i].sh) <= 4) begin
        chk("in_ready_in_shift", 64'(in_ready), 64'(0));
        chk("out_valid_in_shift", 64'(out_valid), 64'(0));
      end
      drain();
      chk("idle_after_result", 64'(out_valid), 64'(0));
    end

    // Backpressure, then handshake and new accept on the same edge.
    out_ready = 1'b0;
    send('{base, 3'd1, 5'd10, mk(8, 7, 6, 5, 4, 3, 2, 1, 0, 10), 1'b0, 2});
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) chk("bp_result_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #2;
    cur.exp_out = mk(19, 19, 19, 19, 19, 19, 19, 19, 19, 19);
    cur.exp_err = 1'b1;
    cur.lat     = 1;
    in_valid    = 1'b1;
    din         = base;
    shift       = 3'd6;
    fill        = 5'd19;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out", 64'(dout), 64'(mk(8, 7, 6, 5, 4, 3, 2, 1, 0, 10)));
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    scramble();
    drain();

    // Asynchronous reset mid-SHIFT abandons the operation.
    send('{base, 3'd3, 5'd9, mk(6, 5, 4, 3, 2, 1, 0, 9, 9, 9), 1'b0, 4});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out", 64'(dout), 64'(0));
    chk("midrst_out_err", 64'(out_err), 64'(0));
    q.delete();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("after_rst_in_ready", 64'(in_ready), 64'(1));
    chk("after_rst_out_valid", 64'(out_valid), 64'(0));
    send('{base, 3'd1, 5'd2, mk(8, 7, 6, 5, 4, 3, 2, 1, 0, 2), 1'b0, 2});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
